swipt_sequencer: RTL

Top-level program sequencer for the SWIPT transmitter. It owns the operating point (`freq`, `l`) driven into SwiptOut and steps the shared program bus through the phases IDLE → frequency optimisation → mean-current measurement → data/power optimisation, handshaking with the Freq, GetMeanCurrent and Data blocks. It handles heartbeat loss and the comms override with fixed priority, and guards the frequency search with a watchdog.

---
 rtl/swipt_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/swipt_sequencer.sv
// swipt_sequencer: program sequencer for the SWIPT transmitter.
// Owns the operating point (freq/l) and steps the program bus through
// IDLE -> FREQ -> MEAS -> DATA. Heartbeat loss takes priority over the comms
// override, and the override takes priority over the phase FSM.
// Optional build macro: SWIPT_SEQ_FREQ_TIMEOUT_EN adds the frequency-phase
// watchdog and the sticky freq_timeout_o flag. Without it, FREQ waits for
// freq_alg_done_i indefinitely and freq_timeout_o is tied low.
// "program" is a reserved word, so every port carries an _i/_o suffix.
module swipt_sequencer #(
  parameter logic [19:0] START_FREQ   = 20'h88B8,
  parameter logic [11:0] START_DUTY   = 12'hC8,
  parameter logic [19:0] MEAS_CYCLES  = 20'hF4240,
  parameter logic [23:0] FREQ_TIMEOUT = 24'hFFFFFF,
  parameter logic [11:0] DUTY_STEP    = 12'h001,
  parameter logic [11:0] DUTY_MIN     = 12'h010,
  parameter logic [11:0] DUTY_MAX     = 12'hF00
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        swipt_alive_i,
  input  logic        comms_valid_i,
  input  logic        comms_release_i,
  input  logic [19:0] comms_freq_i,
  input  logic [11:0] comms_duty_i,
  input  logic [19:0] freq_new_i,
  input  logic [19:0] freq_best_i,
  input  logic        freq_alg_done_i,
  input  logic        mean_req_i,
  input  logic        l_rdy_i,
  input  logic        l_up_down_i,
  output logic [1:0]  program_o,
  output logic [19:0] freq_o,
  output logic [11:0] l_o,
  output logic        measure_o,
  output logic        meas_done_o,
  output logic        override_o,
  output logic        freq_timeout_o
);

  // The state encoding is the program bus code itself, so program_o is the state register.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_FREQ = 2'b01,
    S_MEAS = 2'b10,
    S_DATA = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] freq_q, freq_d;
  logic [11:0] l_q, l_d;
  logic        measure_q, measure_d;
  logic        meas_done_q, meas_done_d;
  logic        override_q, override_d;
  logic [19:0] cnt_q, cnt_d;
  logic [12:0] l_ext;
  logic [11:0] l_step;

`ifdef SWIPT_SEQ_FREQ_TIMEOUT_EN
  logic [23:0] wd_q, wd_d;
  logic        tout_q, tout_d;
`else
  logic        unused_freq_timeout;
  assign unused_freq_timeout = ^FREQ_TIMEOUT;
`endif

  // Saturating duty step: computed in 13 bits so both overflow past 12'hFFF
  // and underflow below zero are caught before clamping into [MIN, MAX].
  always_comb begin
    l_ext  = l_up_down_i ? ({1'b0, l_q} + {1'b0, DUTY_STEP})
                         : ({1'b0, l_q} - {1'b0, DUTY_STEP});
    l_step = l_ext[11:0];
    if (!l_up_down_i && l_ext[12]) l_step = DUTY_MIN;
    else if (l_ext > {1'b0, DUTY_MAX}) l_step = DUTY_MAX;
    else if (l_ext < {1'b0, DUTY_MIN}) l_step = DUTY_MIN;
  end

  // Next-state and output logic in priority order: heartbeat, override, phase FSM.
  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    l_d         = l_q;
    measure_d   = measure_q;
    meas_done_d = 1'b0;
    override_d  = override_q;
    cnt_d       = cnt_q;
`ifdef SWIPT_SEQ_FREQ_TIMEOUT_EN
    wd_d        = wd_q;
    tout_d      = tout_q;
`endif
    if (!swipt_alive_i) begin
      // Heartbeat lost: back to defaults; the timeout flag survives.
      state_d    = S_IDLE;
      freq_d     = START_FREQ;
      l_d        = START_DUTY;
      measure_d  = 1'b0;
      override_d = 1'b0;
      cnt_d      = MEAS_CYCLES;
`ifdef SWIPT_SEQ_FREQ_TIMEOUT_EN
      wd_d       = '0;
`endif
    end else if (comms_valid_i) begin
      // Comms operating point wins over a simultaneous release.
      state_d    = S_IDLE;
      freq_d     = comms_freq_i;
      l_d        = comms_duty_i;
      measure_d  = 1'b0;
      override_d = 1'b1;
      cnt_d      = MEAS_CYCLES;
`ifdef SWIPT_SEQ_FREQ_TIMEOUT_EN
      wd_d       = '0;
`endif
    end else if (override_q) begin
      // Phases are frozen in IDLE; release resumes from IDLE next cycle.
      state_d = S_IDLE;
      if (comms_release_i) override_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_FREQ;
        end
        S_FREQ: begin
          if (freq_alg_done_i) begin
            freq_d    = freq_best_i;
            measure_d = 1'b1;
            state_d   = S_MEAS;
`ifdef SWIPT_SEQ_FREQ_TIMEOUT_EN
            wd_d      = '0;
          end else if (wd_q == FREQ_TIMEOUT) begin
            freq_d    = START_FREQ;
            tout_d    = 1'b1;
            measure_d = 1'b1;
            state_d   = S_MEAS;
            wd_d      = '0;
`endif
          end else begin
            freq_d = freq_new_i;
`ifdef SWIPT_SEQ_FREQ_TIMEOUT_EN
            wd_d   = wd_q + 24'd1;
`endif
          end
        end
        S_MEAS: begin
          // Window covers counter values MEAS_CYCLES..0, i.e. MEAS_CYCLES+1 cycles.
          if (cnt_q == '0) begin
            measure_d   = 1'b0;
            meas_done_d = 1'b1;
            cnt_d       = MEAS_CYCLES;
            state_d     = S_DATA;
          end else begin
            measure_d = 1'b1;
            cnt_d     = cnt_q - 20'd1;
          end
        end
        S_DATA: begin
          measure_d = mean_req_i;
          if (l_rdy_i) l_d = l_step;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q     <= S_IDLE;
      freq_q      <= START_FREQ;
      l_q         <= START_DUTY;
      measure_q   <= 1'b0;
      meas_done_q <= 1'b0;
      override_q  <= 1'b0;
      cnt_q       <= MEAS_CYCLES;
`ifdef SWIPT_SEQ_FREQ_TIMEOUT_EN
      wd_q        <= '0;
      tout_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      l_q         <= l_d;
      measure_q   <= measure_d;
      meas_done_q <= meas_done_d;
      override_q  <= override_d;
      cnt_q       <= cnt_d;
`ifdef SWIPT_SEQ_FREQ_TIMEOUT_EN
      wd_q        <= wd_d;
      tout_q      <= tout_d;
`endif
    end
  end

  assign program_o   = state_q;
  assign freq_o      = freq_q;
  assign l_o         = l_q;
  assign measure_o   = measure_q;
  assign meas_done_o = meas_done_q;
  assign override_o  = override_q;
`ifdef SWIPT_SEQ_FREQ_TIMEOUT_EN
  assign freq_timeout_o = tout_q;
`else
  assign freq_timeout_o = 1'b0;
`endif

endmodule
